// File: rtl/instruction_encoder_if.sv
// instruction_encoder_if: field-bundle handshake and instruction-memory write port of the instruction encoder
// Ports (master = loader/bench side, slave = encoder side):
//   start, finish        session open/close pulses
//   in_valid, in_ready   field-bundle handshake
//   format, opcode, rs, rt, rd, shamt, funct, immediate, address   decoded fields
//   mem_we, mem_addr, mem_wdata   registered instruction-memory write port
//   word_count, busy, done, err   session status
interface instruction_encoder_if #(parameter int ADDR_W = 8);
  logic start;
  logic finish;
  logic in_valid;
  logic in_ready;
  logic [1:0] format;
  logic [5:0] opcode;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic [4:0] shamt;
  logic [5:0] funct;
  logic [15:0] immediate;
  logic [25:0] address;
  logic mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [ADDR_W:0] word_count;
  logic busy;
  logic done;
  logic err;
  modport master (
    output start, finish, in_valid, format, opcode, rs, rt, rd, shamt, funct, immediate, address,
    input in_ready, mem_we, mem_addr, mem_wdata, word_count, busy, done, err
  );
  modport slave (
    input start, finish, in_valid, format, opcode, rs, rt, rd, shamt, funct, immediate, address,
    output in_ready, mem_we, mem_addr, mem_wdata, word_count, busy, done, err
  );
endinterface

// File: rtl/instruction_encoder.sv
// instruction_encoder: packs MIPS-32 R/I/J fields into words and streams them to instruction memory
// Ports: clk (rising edge), reset (sync, active-high), bus (instruction_encoder_if.slave: handshake, fields,
//   write port mem_we/mem_addr/mem_wdata, status word_count/busy/done/err).
// Optional: define INSTR_ENC_CHECK_EN to reject bundles whose opcode is inconsistent with the format.
module instruction_encoder #(
  parameter int ADDR_W = 8,
  parameter int DEPTH = 256
) (
  input logic clk,
  input logic reset,
  instruction_encoder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t state, state_nx;
  logic [ADDR_W:0] cnt;
  logic acc, legal, wr;
  logic [31:0] enc;
  assign bus.in_ready = state == LOAD && cnt < (ADDR_W+1)'(DEPTH);
  assign bus.word_count = cnt;
  assign bus.busy = state == LOAD;
  assign bus.done = state == DONE;
  assign acc = bus.in_valid && bus.in_ready;
  assign wr = acc && legal;
  always_comb begin
    enc = bus.format == 2'd0 ? {6'b000000, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct} :
          bus.format == 2'd1 ? {bus.opcode, bus.rs, bus.rt, bus.immediate} :
                               {bus.opcode, bus.address};
  end
`ifdef INSTR_ENC_CHECK_EN
  always_comb begin
    legal = bus.format == 2'd0 ? bus.opcode == 6'd0 :
            bus.format == 2'd1 ? !(bus.opcode inside {6'd0, 6'd2, 6'd3}) :
            bus.format == 2'd2 ? (bus.opcode == 6'd2 || bus.opcode == 6'd3) : 1'b0;
  end
`else
  always_comb begin
    legal = bus.format != 2'd3;
  end
`endif
  // The write that fills the last slot closes the session on the same edge it is accepted.
  always_comb begin
    state_nx = state;
    state_nx = state == LOAD ? ((bus.finish || (wr && cnt == (ADDR_W+1)'(DEPTH - 1))) ? DONE : LOAD) :
               (bus.start ? LOAD : state);
  end
  always_ff @(posedge clk) begin
    state <= reset ? IDLE : state_nx;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.mem_we <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_wdata <= '0;
      bus.err <= 1'b0;
      cnt <= '0;
    end else begin
      bus.mem_we <= wr;
      if (state != LOAD && bus.start) begin
        bus.mem_addr <= '0;
        bus.err <= 1'b0;
        cnt <= '0;
      end else if (wr) begin
        bus.mem_addr <= cnt[ADDR_W-1:0];
        bus.mem_wdata <= enc;
        cnt <= cnt + 1'b1;
      end else if (acc) begin
        bus.err <= 1'b1;
      end
    end
  end
endmodule
